ex_mult_div_unit: RTL
=====================

// Module: ex_mult_div_unit
// PURPOSE
//  Multi-cycle multiply/divide unit in the EX stage, beside the ALU; owns the HI/LO registers.
//  Executes MULT/MULTU/DIV/DIVU with fixed latency, MTHI/MTLO in one cycle, and MFHI/MFLO reads
//  on MD_Out. The EX result mux forwards MD_Out into the EX/MEM ALU_Out path.
//  Busy drives the hazard unit, which stalls any MD instruction issued while a MULT/DIV is in flight.
// PARAMETERS
//  MULT_CYCLES  5   cycles Busy is high for MULT/MULTU (legal range 1..15)
//  DIV_CYCLES   10  cycles Busy is high for DIV/DIVU (legal range 1..15)
// PORTS
//  clk       in   1   pipeline clock, all state on rising edge
//  reset     in   1   asynchronous, active-high; clears all state immediately
//  MD_Start  in   1   EX holds a valid MD write-class op (MULT/MULTU/DIV/DIVU/MTHI/MTLO) this cycle
//  MD_Op     in   4   operation code (mdu_pkg encoding)
//  A         in   32  rs operand, post-forwarding
//  B         in   32  rt operand, post-forwarding
//  Busy      out  1   multi-cycle operation in flight
//  HI_Out    out  32  current HI register
//  LO_Out    out  32  current LO register
//  MD_Out    out  32  HI if MD_Op==MFHI, LO if MD_Op==MFLO, else 0 (combinational)
// BEHAVIOUR
//  Reset: HI=0, LO=0, Busy=0, count=0, pending results=0; outputs reflect this asynchronously.
//  Reset mid-operation discards the pending result; HI/LO stay 0 and Busy stays 0 until a new Start.
//  States: IDLE (count==0, Busy=0), RUN (count>0, Busy=1). Busy = (count!=0), driven from a register.
//  IDLE, MD_Start, op MULT/MULTU/DIV/DIVU at edge k: latch result into pend_hi/pend_lo,
//    count <= MULT_CYCLES or DIV_CYCLES; Busy high for exactly N cycles after edge k.
//  RUN: count decrements each edge; on the edge where count goes 1->0, HI<=pend_hi, LO<=pend_lo, Busy falls.
//    HI/LO keep their old values for the whole RUN; new values are visible in the cycle after Busy falls.
//  IDLE, MD_Start, MTHI: HI<=A at the next edge. MTLO: LO<=A. Busy stays 0.
//  MD_Start while Busy (any op): ignored completely; the stalled instruction re-presents it later.
//  MD_Start with a non-write op (MFHI/MFLO/NOP): no state change.
//  MFHI/MFLO while Busy: MD_Out returns the old HI/LO; the hazard unit must stall this case.
//  Arithmetic:
//    MULT: signed 32x32->64, {HI,LO}=product. MULTU: unsigned.
//    DIV: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
//    DIVU: unsigned quotient/remainder.
//    DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//    Divide by zero (DIV/DIVU): runs full DIV_CYCLES; at completion HI/LO are left unchanged.
//  No other outputs change on a divide-by-zero.
// STRUCTURE
//  mdu_pkg:
//    MD_Op localparams: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
//    Default MULT_CYCLES/DIV_CYCLES constants, shared with the decoder and hazard unit.
//  One state block: HI, LO, count[3:0], pend_hi, pend_lo.
//  Results are computed combinationally from A/B at Start and captured in pend_*; the
//    multi-cycle latency is modelled timing only.
//  No sub-module; the ALU stays separate.
// TESTING
//  1. MULT A=0xFFFFFFFF B=2 -> Busy high 5 cycles, HI=FFFFFFFF, LO=FFFFFFFE after Busy falls.
//     MULTU, same operands -> HI=00000001, LO=FFFFFFFE.
//  2. DIV A=0xFFFFFFF9(-7) B=2 -> Busy 10 cycles, LO=FFFFFFFD, HI=FFFFFFFF.
//     DIVU A=7 B=2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=80000000, HI=0.
//  3. MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 -> next cycle HI/LO hold those values, Busy=0.
//     MD_Op=MFHI -> MD_Out=12345678.
//  4. MULT issued, then MD_Start DIV on cycle 2 of Busy -> DIV ignored; Busy falls after 5 cycles
//     with the MULT result. MTLO while Busy -> LO unchanged.
//  5. DIV by zero with HI=0xAAAA0000, LO=0x5555 -> Busy 10 cycles; HI/LO unchanged afterwards.
//  6. reset asserted mid-DIV (cycle 4), between clock edges -> Busy, HI, LO go 0 immediately;
//     no late write after reset deasserts.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the EX-stage multiply/divide unit,
// also consumed by the decoder and the hazard unit.
package mdu_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/ex_mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO. Results are computed at issue and
// held in pend_* until the fixed latency expires; Busy stalls further MD ops.
module ex_mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MD_Start,
  input  logic [3:0]  MD_Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI_Out,
  output logic [31:0] LO_Out,
  output logic [31:0] MD_Out
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  mdu_state_e  state, state_next;
  logic [3:0]  count, count_next;
  logic [31:0] hi, hi_next;
  logic [31:0] lo, lo_next;
  logic [31:0] pend_hi, pend_hi_next;
  logic [31:0] pend_lo, pend_lo_next;
  logic        pend_wr, pend_wr_next;

  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b;
  logic        div_ovf;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;

  // Divisor is forced nonzero so the dividers never see 0; the result is discarded then.
  always_comb begin
    prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u  = {32'd0, A} * {32'd0, B};
    div_b   = (B == 32'd0) ? 32'd1 : B;
    div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    if (div_ovf) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'd0;
    end else begin
      quot_s = $signed(A) / $signed(div_b);
      rem_s  = $signed(A) % $signed(div_b);
    end
    quot_u = A / div_b;
    rem_u  = A % div_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      hi      <= hi_next;
      lo      <= lo_next;
      pend_hi <= pend_hi_next;
      pend_lo <= pend_lo_next;
      pend_wr <= pend_wr_next;
    end
  end

  always_comb begin
    state_next   = state;
    count_next   = count;
    hi_next      = hi;
    lo_next      = lo;
    pend_hi_next = pend_hi;
    pend_lo_next = pend_lo;
    pend_wr_next = pend_wr;
    case (state)
      ST_IDLE: begin
        if (MD_Start) begin
          if (is_mul_op(MD_Op)) begin
            state_next   = ST_RUN;
            count_next   = MULT_CNT;
            pend_wr_next = 1'b1;
            pend_hi_next = (MD_Op == MD_MULT) ? prod_s[63:32] : prod_u[63:32];
            pend_lo_next = (MD_Op == MD_MULT) ? prod_s[31:0]  : prod_u[31:0];
          end else if (is_div_op(MD_Op)) begin
            // A zero divisor still occupies the unit but leaves HI/LO untouched.
            state_next   = ST_RUN;
            count_next   = DIV_CNT;
            pend_wr_next = (B != 32'd0);
            pend_hi_next = (MD_Op == MD_DIV) ? rem_s  : rem_u;
            pend_lo_next = (MD_Op == MD_DIV) ? quot_s : quot_u;
          end else if (MD_Op == MD_MTHI) begin
            hi_next = A;
          end else if (MD_Op == MD_MTLO) begin
            lo_next = A;
          end
        end
      end
      ST_RUN: begin
        count_next = count - 4'd1;
        if (count == 4'd1) begin
          state_next   = ST_IDLE;
          pend_wr_next = 1'b0;
          if (pend_wr) begin
            hi_next = pend_hi;
            lo_next = pend_lo;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  assign Busy   = (state == ST_RUN);
  assign HI_Out = hi;
  assign LO_Out = lo;
  assign MD_Out = (MD_Op == MD_MFHI) ? hi :
                  (MD_Op == MD_MFLO) ? lo : 32'd0;

endmodule
